// File: rtl/uart_core_if.sv
// uart_core_if -- parallel-side handshake bundle of the UART core.
//
// Signals
//   tx_data/tx_valid/tx_ready : byte stream into the transmitter (valid/ready)
//   rx_data/rx_valid/rx_ready : byte stream out of the receiver (valid/ready)
//   rx_frame_err              : one-clk pulse, bad stop bit
//   rx_parity_err             : one-clk pulse, parity mismatch on a good stop
//   rx_overrun                : one-clk pulse, good byte lost because rx_valid was still set
//
// Modports
//   master : the user logic that feeds/consumes bytes
//   slave  : the UART core
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// uart_core -- full-duplex UART with 16x oversampling receiver.
//
// Ports
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   rx  : asynchronous serial input (idle high)
//   tx  : serial output (idle high), registered
//   bus : uart_core_if.slave -- tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready,
//         rx_frame_err/rx_parity_err/rx_overrun pulses; all outputs registered
//
// Parameters
//   CLK_DIV   : clk cycles per oversample tick (2..65535); one bit = 16 ticks
//   DATA_BITS : data bits per frame (5..8)
//   PARITY    : 0 none, 1 odd, 2 even
//   STOP_BITS : stop bits sent and checked (1..2)
module uart_core #(
    parameter int CLK_DIV   = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    uart_core_if.slave bus
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 32'sd1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 32'sd1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 32'sd1);
    localparam bit          PAR_EN    = (PARITY != 32'sd0);
    localparam bit          PAR_ODD   = (PARITY == 32'sd1);

    // Parity bit that accompanies a data word for the configured mode.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        return PAR_ODD ? ~(^data) : (^data);
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    logic [15:0]          presc_r;
    logic                 tick_s;
    logic                 rx_meta_r;
    logic                 rx_sync_r;

    tx_state_t            tx_state_r;
    logic [3:0]           tx_cnt_r;
    logic [2:0]           tx_bit_r;
    logic                 tx_stop_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic                 tx_started_r;
    logic                 tx_r;
    logic                 tx_ready_r;

    rx_state_t            rx_state_r;
    logic [3:0]           rx_cnt_r;
    logic [2:0]           rx_bit_r;
    logic                 rx_stop_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_par_bad_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overrun_r;

    // Free-running prescaler; the tick is the last count of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= 16'd0;
        end else if (presc_r == DIV_LAST) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    assign tick_s = (presc_r == DIV_LAST);

    // Two-flop synchronizer for the asynchronous rx line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Transmitter FSM. The byte and its parity are captured at acceptance so
    // later tx_data changes cannot disturb the frame. The start bit waits for
    // the next tick so every bit lasts exactly 16 ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r   <= TX_IDLE;
            tx_cnt_r     <= 4'd0;
            tx_bit_r     <= 3'd0;
            tx_stop_r    <= 1'b0;
            tx_shift_r   <= '0;
            tx_par_r     <= 1'b0;
            tx_started_r <= 1'b0;
            tx_r         <= 1'b1;
            tx_ready_r   <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (bus.tx_valid && tx_ready_r) begin
                        tx_shift_r   <= bus.tx_data;
                        tx_par_r     <= parity_bit(bus.tx_data);
                        tx_ready_r   <= 1'b0;
                        tx_started_r <= 1'b0;
                        tx_state_r   <= TX_START;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tick_s) begin
                        if (!tx_started_r) begin
                            tx_r         <= 1'b0;
                            tx_started_r <= 1'b1;
                            tx_cnt_r     <= 4'd0;
                        end else if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r   <= 4'd0;
                            tx_r       <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                            tx_bit_r   <= 3'd0;
                            tx_state_r <= TX_DATA;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick_s) begin
                        if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r <= 4'd0;
                            if (tx_bit_r == LAST_BIT) begin
                                if (PAR_EN) begin
                                    tx_r       <= tx_par_r;
                                    tx_state_r <= TX_PARITY;
                                end else begin
                                    tx_r       <= 1'b1;
                                    tx_stop_r  <= 1'b0;
                                    tx_state_r <= TX_STOP;
                                end
                            end else begin
                                tx_r       <= tx_shift_r[0];
                                tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                                tx_bit_r   <= tx_bit_r + 3'd1;
                            end
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick_s) begin
                        if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r   <= 4'd0;
                            tx_r       <= 1'b1;
                            tx_stop_r  <= 1'b0;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick_s) begin
                        if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r <= 4'd0;
                            if (tx_stop_r == LAST_STOP) begin
                                tx_ready_r <= 1'b1;
                                tx_state_r <= TX_IDLE;
                            end else begin
                                tx_stop_r <= 1'b1;
                            end
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    tx_ready_r <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Receiver FSM plus output register. A consume (rx_valid && rx_ready) on
    // the same clk as a frame completion frees the slot, so that frame loads
    // instead of overrunning; the later non-blocking write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= 4'd0;
            rx_bit_r     <= 3'd0;
            rx_stop_r    <= 1'b0;
            rx_shift_r   <= '0;
            rx_par_bad_r <= 1'b0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
            if (rx_valid_r && bus.rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            if (tick_s) begin
                case (rx_state_r)
                    RX_IDLE: begin
                        if (!rx_sync_r) begin
                            rx_cnt_r   <= 4'd0;
                            rx_state_r <= RX_START;
                        end
                    end
                    RX_START: begin
                        // Half a bit in: still low means a real start bit.
                        if (rx_cnt_r == 4'd7) begin
                            rx_cnt_r <= 4'd0;
                            if (rx_sync_r) begin
                                rx_state_r <= RX_IDLE;
                            end else begin
                                rx_bit_r     <= 3'd0;
                                rx_par_bad_r <= 1'b0;
                                rx_state_r   <= RX_DATA;
                            end
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt_r == 4'd15) begin
                            rx_cnt_r   <= 4'd0;
                            rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                            if (rx_bit_r == LAST_BIT) begin
                                rx_stop_r  <= 1'b0;
                                rx_state_r <= PAR_EN ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_r <= rx_bit_r + 3'd1;
                            end
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_cnt_r == 4'd15) begin
                            rx_cnt_r     <= 4'd0;
                            rx_par_bad_r <= (rx_sync_r != parity_bit(rx_shift_r));
                            rx_state_r   <= RX_STOP;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt_r == 4'd15) begin
                            rx_cnt_r <= 4'd0;
                            if (!rx_sync_r) begin
                                frame_err_r <= 1'b1;
                                rx_state_r  <= RX_WAIT_HIGH;
                            end else if (rx_stop_r != LAST_STOP) begin
                                rx_stop_r <= 1'b1;
                            end else begin
                                rx_state_r <= RX_IDLE;
                                if (rx_par_bad_r) begin
                                    parity_err_r <= 1'b1;
                                end else if (!rx_valid_r || bus.rx_ready) begin
                                    rx_data_r  <= rx_shift_r;
                                    rx_valid_r <= 1'b1;
                                end else begin
                                    overrun_r <= 1'b1;
                                end
                            end
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                    RX_WAIT_HIGH: begin
                        // A line stuck low after a framing error must not
                        // look like a fresh start bit.
                        if (rx_sync_r) begin
                            rx_state_r <= RX_IDLE;
                        end
                    end
                    default: begin
                        rx_state_r <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx                = tx_r;
    assign bus.tx_ready      = tx_ready_r;
    assign bus.rx_data       = rx_data_r;
    assign bus.rx_valid      = rx_valid_r;
    assign bus.rx_frame_err  = frame_err_r;
    assign bus.rx_parity_err = parity_err_r;
    assign bus.rx_overrun    = overrun_r;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core -- directed, table-driven bench for uart_core at CLK_DIV=4
// (one bit = 64 clks). dut0 is 8N1, dut2 is 8E1. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_uart_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rx_drv0 = 1'b1;
    logic rx_drv2 = 1'b1;
    logic loop_en = 1'b0;
    logic tx0, tx2, rx0, rx2;

    assign rx0 = loop_en ? tx0 : rx_drv0;
    assign rx2 = rx_drv2;

    uart_core_if #(.DATA_BITS(8)) bus0 ();
    uart_core_if #(.DATA_BITS(8)) bus2 ();

    uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .tx(tx0), .bus(bus0.slave)
    );

    uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .tx(tx2), .bus(bus2.slave)
    );

    // Pulse counters and rx_valid rising-edge timestamp.
    int   fe0 = 0, pe0 = 0, ov0 = 0, fe2 = 0, pe2 = 0, ov2 = 0;
    int   last_rise0 = 0;
    logic prev_v0 = 1'b0;
    always @(negedge clk) begin
        fe0 <= fe0 + (bus0.rx_frame_err  ? 1 : 0);
        pe0 <= pe0 + (bus0.rx_parity_err ? 1 : 0);
        ov0 <= ov0 + (bus0.rx_overrun    ? 1 : 0);
        fe2 <= fe2 + (bus2.rx_frame_err  ? 1 : 0);
        pe2 <= pe2 + (bus2.rx_parity_err ? 1 : 0);
        ov2 <= ov2 + (bus2.rx_overrun    ? 1 : 0);
        prev_v0 <= bus0.rx_valid;
        if (bus0.rx_valid && !prev_v0) last_rise0 <= cyc;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int w, input logic b);
        if (w == 0) rx_drv0 = b;
        else        rx_drv2 = b;
    endtask

    function automatic logic rd_valid(input int w);
        return (w == 0) ? bus0.rx_valid : bus2.rx_valid;
    endfunction
    function automatic logic [7:0] rd_data(input int w);
        return (w == 0) ? bus0.rx_data : bus2.rx_data;
    endfunction
    function automatic int rd_fe(input int w);
        return (w == 0) ? fe0 : fe2;
    endfunction
    function automatic int rd_pe(input int w);
        return (w == 0) ? pe0 : pe2;
    endfunction
    function automatic int rd_ov(input int w);
        return (w == 0) ? ov0 : ov2;
    endfunction

    // Bit-bang one frame (64 clks per bit), optionally hold low after the
    // stop bit, then idle high for one bit time.
    task automatic drive_frame(input int w, input logic [7:0] d, input bit has_par,
                               input bit par_v, input bit stop_v, input int hold_low);
        set_rx(w, 1'b0);
        step(64);
        for (int i = 0; i < 8; i++) begin
            set_rx(w, d[i]);
            step(64);
        end
        if (has_par) begin
            set_rx(w, par_v);
            step(64);
        end
        set_rx(w, stop_v);
        step(64);
        if (hold_low > 0) begin
            set_rx(w, 1'b0);
            step(hold_low);
        end
        set_rx(w, 1'b1);
        step(64);
    endtask

    task automatic consume(input int w);
        if (w == 0) bus0.rx_ready = 1'b1;
        else        bus2.rx_ready = 1'b1;
        step(1);
        bus0.rx_ready = 1'b0;
        bus2.rx_ready = 1'b0;
    endtask

    task automatic align4();
        while ((cyc % 4) != 0) step(1);
    endtask

    typedef struct {
        int         which;
        logic [7:0] data;
        bit         has_par;
        bit         par_v;
        bit         stop_v;
        bit         consume;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_pe;
        int         exp_ov;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int         fe_b, pe_b, ov_b, t0, offset, n;
    logic [7:0] txd;
    logic       exp_bit, bad;

    initial begin
        bus0.tx_data = 8'h00; bus0.tx_valid = 1'b0; bus0.rx_ready = 1'b0;
        bus2.tx_data = 8'h00; bus2.tx_valid = 1'b0; bus2.rx_ready = 1'b0;

        //          w  data  par pv  stop cons  vld  exp    fe pe ov
        vecs[0] = '{0, 8'h3C, 0, 0, 0, 0, 1'b0, 8'h00, 1, 0, 0};
        vecs[1] = '{0, 8'hA5, 0, 0, 1, 1, 1'b1, 8'hA5, 0, 0, 0};
        vecs[2] = '{0, 8'h00, 0, 0, 1, 1, 1'b1, 8'h00, 0, 0, 0};
        vecs[3] = '{0, 8'hFF, 0, 0, 1, 1, 1'b1, 8'hFF, 0, 0, 0};
        vecs[4] = '{0, 8'h5A, 0, 0, 1, 1, 1'b1, 8'h5A, 0, 0, 0};
        vecs[5] = '{2, 8'h07, 1, 0, 1, 0, 1'b0, 8'h00, 0, 1, 0};
        vecs[6] = '{2, 8'h07, 1, 1, 1, 1, 1'b1, 8'h07, 0, 0, 0};
        vecs[7] = '{2, 8'h3C, 1, 0, 1, 1, 1'b1, 8'h3C, 0, 0, 0};
        vecs[8] = '{2, 8'h3C, 1, 1, 1, 0, 1'b0, 8'h3C, 0, 1, 0};
        vecs[9] = '{2, 8'h80, 1, 1, 0, 0, 1'b0, 8'h3C, 1, 0, 0};

        // Reset state
        step(5);
        chk("rst_tx",       {31'd0, tx0}, 32'd1);
        chk("rst_tx2",      {31'd0, tx2}, 32'd1);
        chk("rst_tx_ready", {31'd0, bus0.tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus0.rx_valid}, 32'd0);
        chk("rst_rx_data",  {24'd0, bus0.rx_data}, 32'd0);
        chk("rst_err_pulses", {29'd0, bus0.rx_frame_err, bus0.rx_parity_err, bus0.rx_overrun}, 32'd0);
        rst = 1'b0;
        step(1);
        chk("tx_ready_after_rst",  {31'd0, bus0.tx_ready}, 32'd1);
        chk("tx_ready_after_rst2", {31'd0, bus2.tx_ready}, 32'd1);
        step(10);

        // Short low glitch is rejected
        fe_b = fe0;
        rx_drv0 = 1'b0;
        step(20);
        rx_drv0 = 1'b1;
        step(200);
        chk("glitch_rx_valid", {31'd0, bus0.rx_valid}, 32'd0);
        chk("glitch_fe",       fe0 - fe_b, 32'd0);

        // Table of receive frames
        for (int i = 0; i < NV; i++) begin
            fe_b = rd_fe(vecs[i].which);
            pe_b = rd_pe(vecs[i].which);
            ov_b = rd_ov(vecs[i].which);
            drive_frame(vecs[i].which, vecs[i].data, vecs[i].has_par, vecs[i].par_v, vecs[i].stop_v, 0);
            chk($sformatf("v%0d_valid", i), {31'd0, rd_valid(vecs[i].which)}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_data", i),  {24'd0, rd_data(vecs[i].which)},  {24'd0, vecs[i].exp_data});
            chk($sformatf("v%0d_frame_err", i),  rd_fe(vecs[i].which) - fe_b, vecs[i].exp_fe);
            chk($sformatf("v%0d_parity_err", i), rd_pe(vecs[i].which) - pe_b, vecs[i].exp_pe);
            chk($sformatf("v%0d_overrun", i),    rd_ov(vecs[i].which) - ov_b, vecs[i].exp_ov);
            if (vecs[i].consume) consume(vecs[i].which);
        end

        // Overrun, then consume on the exact completion clk of a 3rd frame
        align4();
        t0 = cyc;
        ov_b = ov0;
        drive_frame(0, 8'h11, 0, 0, 1, 0);
        offset = last_rise0 - t0;
        chk("ovr_latency_range", {31'd0, (offset >= 596 && offset <= 624)}, 32'd1);
        chk("ovr_first_data",  {24'd0, bus0.rx_data}, 32'h11);
        drive_frame(0, 8'h22, 0, 0, 1, 0);
        chk("ovr_kept_data",   {24'd0, bus0.rx_data}, 32'h11);
        chk("ovr_kept_valid",  {31'd0, bus0.rx_valid}, 32'd1);
        chk("ovr_pulse_count", ov0 - ov_b, 32'd1);
        align4();
        t0 = cyc;
        ov_b = ov0;
        fork
            drive_frame(0, 8'h33, 0, 0, 1, 0);
            begin
                while (cyc < t0 + offset - 1) step(1);
                bus0.rx_ready = 1'b1;
                step(1);
                bus0.rx_ready = 1'b0;
            end
        join
        chk("simul_data",    {24'd0, bus0.rx_data}, 32'h33);
        chk("simul_valid",   {31'd0, bus0.rx_valid}, 32'd1);
        chk("simul_overrun", ov0 - ov_b, 32'd0);
        consume(0);

        // Framing error with the line held low afterwards
        fe_b = fe0;
        drive_frame(0, 8'h3C, 0, 0, 0, 300);
        chk("waithigh_fe",    fe0 - fe_b, 32'd1);
        chk("waithigh_valid", {31'd0, bus0.rx_valid}, 32'd0);
        drive_frame(0, 8'h5A, 0, 0, 1, 0);
        chk("waithigh_next_data",  {24'd0, bus0.rx_data}, 32'h5A);
        chk("waithigh_next_valid", {31'd0, bus0.rx_valid}, 32'd1);
        chk("waithigh_next_fe",    fe0 - fe_b, 32'd1);
        consume(0);

        // Transmit 0x55, changing tx_data mid-frame
        txd = 8'h55;
        bus0.tx_data  = txd;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_valid = 1'b0;
        bus0.tx_data  = 8'h00;
        chk("tx_ready_drop", {31'd0, bus0.tx_ready}, 32'd0);
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin
            step(1);
            n++;
        end
        chk("tx_start_seen", {31'd0, tx0}, 32'd0);
        n = 0;
        while (1) begin
            step(1);
            n++;
            if ((n % 64) == 32 && n < 640) begin
                if (n / 64 == 0)      exp_bit = 1'b0;
                else if (n / 64 == 9) exp_bit = 1'b1;
                else                  exp_bit = txd[n / 64 - 1];
                chk($sformatf("tx_bit%0d", n / 64), {31'd0, tx0}, {31'd0, exp_bit});
            end
            if (bus0.tx_ready || n >= 800) break;
        end
        chk("tx_frame_clks", n, 32'd640);
        chk("tx_idle_high",  {31'd0, tx0}, 32'd1);

        // Loopback 0xA3
        loop_en = 1'b1;
        step(2);
        fe_b = fe0; pe_b = pe0; ov_b = ov0;
        bus0.tx_data  = 8'hA3;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_valid = 1'b0;
        n = 0;
        while (!bus0.rx_valid && n < 1500) begin
            step(1);
            n++;
        end
        chk("loop_valid",  {31'd0, bus0.rx_valid}, 32'd1);
        chk("loop_data",   {24'd0, bus0.rx_data}, 32'hA3);
        chk("loop_errors", (fe0 - fe_b) + (pe0 - pe_b) + (ov0 - ov_b), 32'd0);
        consume(0);
        step(70);

        // Reset in the middle of a looped-back frame
        bus0.tx_data  = 8'h0F;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_valid = 1'b0;
        step(300);
        rst = 1'b1;
        step(3);
        chk("midrst_tx",       {31'd0, tx0}, 32'd1);
        chk("midrst_tx_ready", {31'd0, bus0.tx_ready}, 32'd0);
        chk("midrst_rx_data",  {24'd0, bus0.rx_data}, 32'd0);
        rst = 1'b0;
        fe_b = fe0; pe_b = pe0; ov_b = ov0;
        bad = 1'b0;
        for (int i = 0; i < 900; i++) begin
            step(1);
            if (bus0.rx_valid || tx0 !== 1'b1) bad = 1'b1;
        end
        chk("midrst_quiet",   {31'd0, bad}, 32'd0);
        chk("midrst_errors",  (fe0 - fe_b) + (pe0 - pe_b) + (ov0 - ov_b), 32'd0);
        chk("midrst_tx_ready_back", {31'd0, bus0.tx_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 104, clk cycles per oversample tick (legal 2..65535).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-003 SHALL provide parameter PARITY, default 0, 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits transmitted and checked (legal 1..2).
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial input, idle high.
REQ-008 SHALL have port tx, output, 1 bit: serial output, idle high.
REQ-009 SHALL have port tx_data, input, DATA_BITS wide: byte to send.
REQ-010 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-011 SHALL have port tx_ready, output, 1 bit: transmitter can accept data.
REQ-012 SHALL have port rx_data, output, DATA_BITS wide: last received byte.
REQ-013 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-014 SHALL have port rx_ready, input, 1 bit: consumer takes rx_data.
REQ-015 SHALL have ports rx_frame_err, rx_parity_err and rx_overrun, outputs, 1 bit each: single-cycle error pulses.

Function
REQ-016 SHALL generate a one-clk tick every CLK_DIV clks from a free-running prescaler (0..CLK_DIV-1); bit period = 16 ticks.
REQ-017 SHALL pass rx through a 2-flop synchronizer clocked every clk, reset value 1; receiver uses the synchronized value only.
REQ-018 Receiver SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; all advance on ticks only.
REQ-019 IDLE: on a sampled low SHALL enter START with tick counter cleared.
REQ-020 START: at tick 7, if the line is high SHALL return to IDLE (glitch rejection); otherwise SHALL enter DATA with the counter cleared.
REQ-021 DATA: SHALL sample every 16th tick (mid-bit), LSB first, for DATA_BITS bits, then enter PARITY (if PARITY != 0) or STOP.
REQ-022 PARITY: SHALL sample at 16 ticks; mismatch against the odd/even XOR of the data bits marks a parity error.
REQ-023 STOP: SHALL check STOP_BITS mid-bit samples; any low sample pulses rx_frame_err for 1 clk, discards the byte and enters WAIT_HIGH.
REQ-024 WAIT_HIGH: SHALL go to IDLE on the first sampled high.
REQ-025 On a good stop with a parity error SHALL pulse rx_parity_err, discard the byte and go to IDLE.
REQ-026 On a good frame with rx_valid low SHALL load rx_data and set rx_valid the next clk.
REQ-027 On a good frame with rx_valid high SHALL keep the old rx_data, pulse rx_overrun for 1 clk and discard the new byte.
REQ-028 rx_valid SHALL clear on the clk where rx_valid && rx_ready; a simultaneous frame completion on that same clk SHALL load normally (no overrun).
REQ-029 Transmitter SHALL use states IDLE, START, DATA, PARITY, STOP; tx_ready = 1 only in IDLE.
REQ-030 On tx_valid && tx_ready SHALL latch tx_data, drop tx_ready next clk, and drive tx low at the next tick.
REQ-031 Transmitter SHALL hold each bit 16 ticks, sending start, then DATA_BITS LSB first, then parity (if enabled), then STOP_BITS high bits.
REQ-032 Transmitter SHALL re-assert tx_ready on the clk after the last stop bit's 16th tick; back-to-back frames SHALL have no extra idle bit.
REQ-033 Changes to tx_data while a frame is transmitting SHALL NOT affect that frame.

Reset
REQ-034 While rst is high SHALL force: tx = 1, tx_ready = 0, rx_valid = 0, rx_data = 0, error pulses = 0, prescaler = 0, synchronizers = 1, both FSMs = IDLE.
REQ-035 tx_ready SHALL rise the clk after rst deasserts.
REQ-036 Reset mid-frame SHALL abort both directions with no partial rx_valid and no error pulse.

Verification (CLK_DIV=4, bit = 64 clks)
REQ-037 Send 0x55 with 8N1 -> tx low 64 clks, then 1,0,1,0,1,0,1,0 at 64 clks each, then high; tx_ready returns after 640 clks.
REQ-038 Loop tx to rx, send 0xA3 -> rx_valid=1 with rx_data=0xA3, no error pulse.
REQ-039 Drive rx low 20 clks, then high -> no state change, rx_valid stays 0.
REQ-040 Frame 0x3C with stop bit forced low -> one rx_frame_err pulse, rx_valid 0; rx accepts the next frame only after the line returns high.
REQ-041 PARITY=2, frame 0x07 with parity bit 0 -> one rx_parity_err pulse and the byte is dropped; with parity bit 1 -> rx_data=0x07.
REQ-042 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11 and one rx_overrun pulse; assert rx_ready the clk the 3rd frame completes -> rx_data loads the 3rd frame with no overrun.
